tx_nrzi_stuffer: RTL and testbench

- Downstream stage of the USB TX parallel-to-serial shift register.
- Takes the serial bit stream from that register and times it at one bit per CLKS_PER_BIT clocks.
- Inserts a stuffed 0 after every six consecutive 1s, NRZI-encodes the result, and drives the differential D+/D- lines.
- Generates EOP (SE0, SE0, J) on request and throttles the shift register through a one-cycle shift_enable strobe per consumed bit.

---
 rtl/tx_nrzi_stuffer_if.sv | 28 ++
 rtl/tx_nrzi_stuffer.sv | 113 +++++++++++
 tb/tb_tx_nrzi_stuffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_nrzi_stuffer_if.sv
// USB TX serializer handshake bundle.
// Master is the packet controller, slave is the NRZI/stuffer stage.
interface tx_nrzi_stuffer_if;
  logic tx_active;
  logic serial_in;
  logic send_eop;
  logic shift_enable;
  logic busy;
  logic eop_done;

  modport master (
    output tx_active,
    output serial_in,
    output send_eop,
    input  shift_enable,
    input  busy,
    input  eop_done
  );

  modport slave (
    input  tx_active,
    input  serial_in,
    input  send_eop,
    output shift_enable,
    output busy,
    output eop_done
  );
endinterface

// File: rtl/tx_nrzi_stuffer.sv
// USB TX back end: bit timing, bit stuffing, NRZI encoding,
// EOP generation and D+/D- drive.
module tx_nrzi_stuffer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6
) (
  input  logic               clk,
  input  logic               rst,
  tx_nrzi_stuffer_if.slave   bus,
  output logic               d_plus,
  output logic               d_minus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(STUFF_LEN + 1);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] O_MAX  = CW'(STUFF_LEN);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] EOP1  = 3'd2;
  localparam logic [2:0] EOP2  = 3'd3;
  localparam logic [2:0] EOP_J = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [CW-1:0] ones_cnt;
  logic          eop_done_q;

  logic is_idle;
  logic strobe;
  logic slot;
  logic do_stuff;
  logic do_eop;
  logic do_bit;

  assign is_idle = (state == IDLE);
  assign strobe  = is_idle ? bus.tx_active
                           : (timer == T_LAST);

  // IDLE and DATA strobes both resolve a data slot
  assign slot     = strobe & (is_idle | (state == DATA));
  assign do_stuff = slot & (ones_cnt == O_MAX);
  assign do_eop   = slot & ~do_stuff
                  & (state == DATA) & bus.send_eop;
  assign do_bit   = slot & ~do_stuff & ~do_eop;

  assign bus.shift_enable = do_bit;
  assign bus.busy         = ~is_idle;
  assign bus.eop_done     = eop_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      ones_cnt   <= '0;
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
      eop_done_q <= 1'b0;
    end else begin
      eop_done_q <= 1'b0;

      if (is_idle || timer == T_LAST)
        timer <= '0;
      else
        timer <= timer + TW'(1);

      unique case (1'b1)
        do_stuff: begin
          d_plus   <= d_minus;
          d_minus  <= d_plus;
          ones_cnt <= '0;
          state    <= DATA;
        end
        do_eop: begin
          d_plus   <= 1'b0;
          d_minus  <= 1'b0;
          ones_cnt <= '0;
          state    <= EOP1;
        end
        do_bit: begin
          state <= DATA;
          if (bus.serial_in) begin
            ones_cnt <= ones_cnt + CW'(1);
          end else begin
            d_plus   <= d_minus;
            d_minus  <= d_plus;
            ones_cnt <= '0;
          end
        end
        strobe && state == EOP1: begin
          d_plus  <= 1'b0;
          d_minus <= 1'b0;
          state   <= EOP2;
        end
        strobe && state == EOP2: begin
          d_plus  <= 1'b1;
          d_minus <= 1'b0;
          state   <= EOP_J;
        end
        strobe && state == EOP_J: begin
          d_plus     <= 1'b1;
          d_minus    <= 1'b0;
          eop_done_q <= 1'b1;
          state      <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_nrzi_stuffer.sv
// Randomized bench for tx_nrzi_stuffer with a slot-level
// reference model of stuffing, NRZI and EOP.
module tb_tx_nrzi_stuffer;
  localparam int CPB = 8;
  localparam int SL  = 6;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst;
  logic d_plus;
  logic d_minus;

  tx_nrzi_stuffer_if bus();

  tx_nrzi_stuffer #(
    .CLKS_PER_BIT(CPB),
    .STUFF_LEN(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .d_plus(d_plus),
    .d_minus(d_minus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit         bits[64];
  int         nb;
  logic [1:0] sym[160];
  bit         shf[160];
  int         ns;
  int         ptr;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs();
    return {d_plus, d_minus, bus.shift_enable,
            bus.busy, bus.eop_done};
  endfunction

  // Line symbol and consume flag for every bit slot of a packet
  function automatic void model();
    logic [1:0] lvl;
    int ones;
    int idx;
    lvl  = J;
    ones = 0;
    idx  = 0;
    ns   = 0;
    while (ns < 150) begin
      if (ones == SL) begin
        lvl     = {lvl[0], lvl[1]};
        ones    = 0;
        sym[ns] = lvl;
        shf[ns] = 1'b0;
      end else if (idx == nb) begin
        sym[ns]   = SE0;
        shf[ns]   = 1'b0;
        sym[ns+1] = SE0;
        shf[ns+1] = 1'b0;
        sym[ns+2] = J;
        shf[ns+2] = 1'b0;
        ns += 3;
        break;
      end else begin
        if (bits[idx]) begin
          ones++;
        end else begin
          lvl  = {lvl[0], lvl[1]};
          ones = 0;
        end
        idx++;
        sym[ns] = lvl;
        shf[ns] = 1'b1;
      end
      ns++;
    end
  endfunction

  task automatic drive_in();
    bus.serial_in = (ptr < nb) ? bits[ptr] : 1'b0;
    bus.send_eop  = (ptr >= nb);
  endtask

  task automatic idle_cycles(input int k, input bit done0);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("idle", 8'(obs()),
          8'({J, 1'b0, 1'b0, done0 && i == 0}));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_byte(input logic [7:0] b, input int at);
    for (int i = 0; i < 8; i++) bits[at+i] = b[i];
  endtask

  task automatic run_packet(input bit done0,
                            input bit keep,
                            input bit abort_eop1);
    logic [4:0] e;
    bit sh;
    int ab;
    model();
    ab  = abort_eop1 ? CPB * (ns - 3) + 4 : -1;
    ptr = 0;
    drive_in();
    bus.tx_active = 1'b1;
    for (int c = 0; c <= CPB * ns; c++) begin
      e[4:3] = (c == 0) ? J : sym[(c-1)/CPB];
      e[2]   = (c % CPB == 0) && (c / CPB < ns)
             && shf[c/CPB];
      e[1]   = (c >= 1);
      e[0]   = (c == 0) && done0;
      @(negedge clk);
      chk("pkt", 8'(obs()), 8'(e));
      sh = bus.shift_enable;
      if (c == ab) begin
        rst = 1'b1;
        bus.tx_active = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (sh) ptr++;
      drive_in();
      if (c == 0) bus.tx_active = keep;
    end
  endtask

  initial begin
    bit prev_keep;
    bit keep;
    rst           = 1'b1;
    bus.tx_active = 1'b0;
    bus.serial_in = 1'b0;
    bus.send_eop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(50, 1'b0);

    // sync byte
    nb = 8;
    load_byte(8'h80, 0);
    run_packet(1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b1);

    // sync then 0xFF, stuffing inside the byte
    nb = 16;
    load_byte(8'h80, 0);
    load_byte(8'hFF, 8);
    run_packet(1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b1);

    // six ones then EOP request: stuff wins first
    nb = 6;
    for (int i = 0; i < 6; i++) bits[i] = 1'b1;
    run_packet(1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b1);

    // back to back with tx_active held
    nb = 8;
    load_byte(8'h80, 0);
    run_packet(1'b0, 1'b1, 1'b0);
    nb = 12;
    for (int i = 0; i < nb; i++) bits[i] = 1'($urandom);
    run_packet(1'b1, 1'b0, 1'b0);
    idle_cycles(2, 1'b1);

    // reset during EOP1 SE0
    nb = 8;
    load_byte(8'h80, 0);
    run_packet(1'b0, 1'b0, 1'b1);
    idle_cycles(10, 1'b0);

    // random packets, ones-heavy, some chained
    prev_keep = 1'b0;
    for (int p = 0; p < 14; p++) begin
      nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++)
        bits[i] = ($urandom % 4) != 0;
      keep = (p != 13) && ($urandom % 3 == 0);
      run_packet(prev_keep, keep, 1'b0);
      if (!keep) idle_cycles($urandom_range(1, 4), 1'b1);
      prev_keep = keep;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
